mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the wait-cycle limit before a transaction is aborted (used only with MEM_ARB_TIMEOUT_EN).
REQ-002 SHALL have parameter STARVE_MAX, default 4, meaning the maximum consecutive data grants made while fetch is waiting.
REQ-003 SHALL have port clk, input, 1, the single clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port if_req, input, 1, instruction-fetch request, held until if_valid.
REQ-006 SHALL have port if_addr, input, 32, fetch address.
REQ-007 SHALL have port if_rdata, output, 32, fetched instruction.
REQ-008 SHALL have port if_valid, output, 1, one-cycle fetch completion pulse.
REQ-009 SHALL have port dm_req, input, 1, data request, held until dm_valid.
REQ-010 SHALL have port dm_we, input, 1, data write enable.
REQ-011 SHALL have port dm_addr, input, 32, data address.
REQ-012 SHALL have port dm_wdata, input, 32, store data.
REQ-013 SHALL have port dm_be, input, 4, store byte enables.
REQ-014 SHALL have port dm_rdata, output, 32, load data, unextended.
REQ-015 SHALL have port dm_valid, output, 1, one-cycle data completion pulse.
REQ-016 SHALL have ports mem_req (1), mem_we (1), mem_addr (32), mem_wdata (32) and mem_be (4), all outputs, forming the shared memory port request.
REQ-017 SHALL have ports mem_ready (1) and mem_rdata (32), both inputs, forming the memory completion strobe and read data.
REQ-018 SHALL have port cpu_stall, output, 1, stall to the CPU pipeline.
REQ-019 SHALL have port bus_err, output, 1, one-cycle abort pulse.

Function
REQ-020 SHALL implement FSM states IDLE, IF_ACC and DM_ACC.
REQ-021 SHALL, in IDLE with any request, grant at the next edge:
- DM_ACC if dm_req and (!if_req or starve_cnt<STARVE_MAX);
- otherwise IF_ACC.
REQ-022 SHALL register the granted address, write data, we and byte enables at the grant edge, and hold them stable until completion.
REQ-023 SHALL drive mem_req=1 only in IF_ACC or DM_ACC, with the following fields:
- fetch: mem_we=0, mem_be=4'b1111;
- data read: mem_be=4'b1111;
- data write: mem_be=dm_be.
REQ-024 SHALL, on a cycle in an ACC state with mem_ready=1:
- capture mem_rdata into if_rdata or dm_rdata;
- pulse the matching valid for one cycle at the next edge;
- return to IDLE.
REQ-025 SHALL give a minimum latency of 2 cycles from request assertion to valid, and SHALL NOT issue back-to-back grants (one IDLE cycle between transactions).
REQ-026 SHALL complete an in-flight transaction normally if its request deasserts mid-transaction.
REQ-027 SHALL increment starve_cnt (saturating at STARVE_MAX) on each data grant made while if_req=1, and SHALL clear it on each fetch grant.
REQ-028 SHALL drive cpu_stall combinationally as (if_req & !if_valid) | (dm_req & !dm_valid).
REQ-029 SHALL hold if_rdata and dm_rdata at their last captured values between transactions.

Reset
REQ-030 SHALL, while rst=0, asynchronously force:
- state=IDLE and starve_cnt=0;
- mem_req, mem_we, if_valid, dm_valid and bus_err to 0;
- mem_addr, mem_wdata, if_rdata and dm_rdata to 32'h0, and mem_be to 4'h0.
REQ-031 SHALL abandon any in-flight transaction on reset without emitting a valid pulse.

Configuration
REQ-032 SHALL, when macro MEM_ARB_TIMEOUT_EN is defined:
- count cycles spent in an ACC state;
- when the count reaches TIMEOUT without mem_ready, return to IDLE;
- pulse the matching valid with rdata 32'h0, together with a one-cycle bus_err pulse.
REQ-033 SHALL, when MEM_ARB_TIMEOUT_EN is defined and mem_ready coincides with the timeout cycle, complete normally with no bus_err.
REQ-034 SHALL, when MEM_ARB_TIMEOUT_EN is undefined, wait indefinitely for mem_ready, tie bus_err to 0, and contain no timeout counter logic.

Verification
REQ-035 Single fetch: if_req=1, if_addr=32'h0000_0040, mem_ready one cycle after mem_req, mem_rdata=32'h0010_0093 -> if_valid pulse with if_rdata=32'h0010_0093, mem_we=0, mem_be=4'hF.
REQ-036 Byte store: dm_req=1, dm_we=1, dm_addr=32'h0000_0103, dm_be=4'b1000, dm_wdata=32'hAB00_0000 -> mem_we=1, mem_be=4'b1000, dm_valid once, cpu_stall high until the dm_valid cycle.
REQ-037 Contention: if_req and dm_req held high with immediate mem_ready -> grant order DM,DM,DM,DM,IF repeating (STARVE_MAX=4).
REQ-038 Reset mid-transaction: rst=0 while in DM_ACC -> mem_req=0 immediately, no dm_valid pulse, state IDLE after release.
REQ-039 Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT=16): mem_ready held 0 -> after 16 ACC cycles, dm_valid and bus_err pulse with dm_rdata=32'h0; without the macro, mem_req stays high for 100+ cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: instruction fetch and data port share one memory port.
// Optional per-transaction timeout is enabled with the MEM_ARB_TIMEOUT_EN macro.
module mem_arbiter #(
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        cpu_stall,
  output logic        bus_err
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC} state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic          dm_side;
  logic          dm_wins;

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("mem_arbiter: TIMEOUT must be at least 1");
  end

  assign dm_side   = (state == DM_ACC);
  assign dm_wins   = dm_req && (!if_req || (starve_cnt < SW'(STARVE_MAX)));
  assign cpu_stall = (if_req & ~if_valid) | (dm_req & ~dm_valid);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_be     <= 4'h0;
      if_rdata   <= 32'h0;
      dm_rdata   <= 32'h0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      bus_err    <= 1'b0;
      wait_cnt   <= '0;
`endif
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      bus_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          if (dm_wins) begin
            state     <= DM_ACC;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_we ? dm_be : 4'hF;
            // Only data grants that bypass a waiting fetch count toward starvation
            if (if_req && (starve_cnt != SW'(STARVE_MAX)))
              starve_cnt <= starve_cnt + SW'(1);
          end else if (if_req) begin
            state      <= IF_ACC;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_be     <= 4'hF;
            starve_cnt <= '0;
          end
        end
        default: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (dm_side) begin
              dm_rdata <= mem_rdata;
              dm_valid <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          // Abort on the TIMEOUT-th access cycle; a coincident mem_ready wins above
          else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            if (dm_side) begin
              dm_rdata <= 32'h0;
              dm_valid <= 1'b1;
            end else begin
              if_rdata <= 32'h0;
              if_valid <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected memory grants and completions.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = 32'h0;
  logic [31:0] dm_wdata = 32'h0;
  logic [3:0]  dm_be = 4'h0;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        cpu_stall, bus_err;

  logic        ready_en = 1'b0;
  logic        use_fixed = 1'b0;
  logic [31:0] rdata_drv = 32'h0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    bit          err;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign mem_ready = mem_req & ready_en;
  assign mem_rdata = use_fixed ? rdata_drv : (mem_addr ^ 32'hA5A5_0F0F);

  mem_arbiter #(.TIMEOUT(16), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .cpu_stall(cpu_stall), .bus_err(bus_err)
  );

  function automatic exp_t mk(bit is_dm, logic we, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, logic [3:0] be, bit err);
    exp_t e;
    e.is_dm = is_dm; e.we = we; e.addr = addr; e.wdata = wdata;
    e.rdata = rdata; e.be = be; e.err = err;
    return e;
  endfunction

  // Scoreboard: peek on each new grant, pop on each completion pulse
  task automatic monitor();
    exp_t        e;
    logic        req_q = 1'b0;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mem_req && !req_q) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL grant: unexpected mem_req addr=%h, required no request", mem_addr);
          end else if (mem_addr !== exp_q[0].addr || mem_we !== exp_q[0].we ||
                       mem_be !== exp_q[0].be ||
                       (exp_q[0].we && mem_wdata !== exp_q[0].wdata)) begin
            fails++;
            $display("FAIL grant: got addr=%h we=%b be=%h wdata=%h, required addr=%h we=%b be=%h wdata=%h",
                     mem_addr, mem_we, mem_be, mem_wdata,
                     exp_q[0].addr, exp_q[0].we, exp_q[0].be, exp_q[0].wdata);
          end
        end
        if (if_valid || dm_valid) begin
          tests++;
          got = dm_valid ? dm_rdata : if_rdata;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL completion: unexpected valid if=%b dm=%b", if_valid, dm_valid);
          end else begin
            e = exp_q.pop_front();
            if (if_valid !== !e.is_dm || dm_valid !== e.is_dm || bus_err !== e.err || got !== e.rdata) begin
              fails++;
              $display("FAIL completion: got if_v=%b dm_v=%b err=%b rdata=%h, required if_v=%b dm_v=%b err=%b rdata=%h",
                       if_valid, dm_valid, bus_err, got, !e.is_dm, e.is_dm, e.err, e.rdata);
            end
          end
        end
        if (bus_err && !(if_valid || dm_valid)) begin
          tests++;
          fails++;
          $display("FAIL bus_err: pulse without valid, required valid alongside");
        end
      end
      req_q = mem_req;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({mem_req, mem_we, mem_be, if_valid, dm_valid, bus_err, cpu_stall} !== 10'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_values: req=%b we=%b be=%h addr=%h wdata=%h ifr=%h dmr=%h, required all zero",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_rdata, dm_rdata);
    end
    dm_req = 1'b1;
    #1;
    tests++;
    if (cpu_stall !== 1'b1 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_stall: got stall=%b mem_req=%b, required 1 and 0", cpu_stall, mem_req);
    end
    @(negedge clk);
    dm_req = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got mem_req=%b stall=%b, required 0 and 0", mem_req, cpu_stall);
    end
  endtask

  task automatic run_fetch(input logic [31:0] addr, input logic [31:0] rdata);
    int n = 0;
    use_fixed = 1'b1; rdata_drv = rdata; ready_en = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, addr, 32'h0, rdata, 4'hF, 1'b0));
    if_addr = addr; if_req = 1'b1;
    do begin @(negedge clk); n++; end while (!if_valid && n < 10);
    if_req = 1'b0;
    tests++;
    if (n != 2 || !if_valid) begin
      fails++;
      $display("FAIL fetch_latency: got %0d cycles (valid=%b), required 2", n, if_valid);
    end
  endtask

  task automatic test_single_fetch();
    run_fetch(32'h0000_0040, 32'h0010_0093);
    repeat (3) @(negedge clk);
    tests++;
    if (if_rdata !== 32'h0010_0093 || dm_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rdata_hold: got if=%h dm=%h, required 00100093 and 00000000", if_rdata, dm_rdata);
    end
  endtask

  task automatic test_byte_store();
    int n = 0;
    int bad_stall = 0;
    int extra = 0;
    use_fixed = 1'b1; rdata_drv = 32'h1111_2222; ready_en = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b1, 32'h0000_0103, 32'hAB00_0000, 32'h1111_2222, 4'b1000, 1'b0));
    dm_addr = 32'h0000_0103; dm_wdata = 32'hAB00_0000; dm_be = 4'b1000; dm_we = 1'b1; dm_req = 1'b1;
    #1;
    if (cpu_stall !== 1'b1) bad_stall++;
    do begin
      @(negedge clk); n++;
      if (!dm_valid && cpu_stall !== 1'b1) bad_stall++;
    end while (!dm_valid && n < 10);
    tests++;
    if (!dm_valid || cpu_stall !== 1'b0 || bad_stall != 0) begin
      fails++;
      $display("FAIL store_stall: got valid=%b stall_at_valid=%b early_drops=%0d, required 1, 0, 0",
               dm_valid, cpu_stall, bad_stall);
    end
    dm_req = 1'b0; dm_we = 1'b0;
    repeat (4) begin @(negedge clk); if (dm_valid) extra++; end
    tests++;
    if (extra != 0 || dm_rdata !== 32'h1111_2222) begin
      fails++;
      $display("FAIL store_once: got %0d extra pulses dm_rdata=%h, required 0 and 11112222", extra, dm_rdata);
    end
  endtask

  task automatic test_contention();
    int nv = 0;
    int n = 0;
    use_fixed = 1'b0; ready_en = 1'b1;
    if_addr = 32'h0000_0300; dm_addr = 32'h0000_0200; dm_we = 1'b0; dm_be = 4'b0011;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) exp_q.push_back(mk(1'b0, 1'b0, 32'h300, 32'h0, 32'h300 ^ 32'hA5A5_0F0F, 4'hF, 1'b0));
      else            exp_q.push_back(mk(1'b1, 1'b0, 32'h200, 32'h0, 32'h200 ^ 32'hA5A5_0F0F, 4'hF, 1'b0));
    end
    if_req = 1'b1; dm_req = 1'b1;
    while (nv < 10 && n < 60) begin
      @(negedge clk); n++;
      if (if_valid || dm_valid) nv++;
    end
    if_req = 1'b0; dm_req = 1'b0;
    tests++;
    if (nv != 10 || exp_q.size() != 0 || n != 20) begin
      fails++;
      $display("FAIL contention: got %0d completions in %0d cycles, %0d left, required 10 in 20, 0 left",
               nv, n, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int pulses = 0;
    ready_en = 1'b0;
    exp_q.push_back(mk(1'b1, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 32'h0, 4'b0101, 1'b0));
    dm_addr = 32'h0000_0400; dm_wdata = 32'hCAFE_F00D; dm_be = 4'b0101; dm_we = 1'b1; dm_req = 1'b1;
    do begin @(negedge clk); n++; end while (!mem_req && n < 5);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || dm_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_async: got req=%b we=%b addr=%h dmr=%h, required 0 0 0 0",
               mem_req, mem_we, mem_addr, dm_rdata);
    end
    exp_q.delete();
    @(negedge clk);
    dm_req = 1'b0; dm_we = 1'b0;
    if (dm_valid) pulses++;
    @(negedge clk);
    rst = 1'b1; ready_en = 1'b1;
    repeat (4) begin @(negedge clk); if (dm_valid || mem_req) pulses++; end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL reset_abandon: got %0d valid/request cycles, required 0", pulses);
    end
    run_fetch(32'h0000_0800, 32'h0BAD_CAFE);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int n = 0;
    int bad = 0;
    use_fixed = 1'b1; rdata_drv = 32'h7777_7777; ready_en = 1'b0;
    dm_we = 1'b0; dm_be = 4'h0; dm_addr = 32'h0000_0500;
`ifdef MEM_ARB_TIMEOUT_EN
    exp_q.push_back(mk(1'b1, 1'b0, 32'h500, 32'h0, 32'h0, 4'hF, 1'b1));
    dm_req = 1'b1;
    do begin @(negedge clk); if (mem_req) n++; end while (!dm_valid && n < 40);
    dm_req = 1'b0;
    tests++;
    if (n != 16 || !dm_valid || bus_err !== 1'b1 || dm_rdata !== 32'h0) begin
      fails++;
      $display("FAIL timeout_abort: got %0d acc cycles valid=%b err=%b rdata=%h, required 16 1 1 0",
               n, dm_valid, bus_err, dm_rdata);
    end
    repeat (2) @(negedge clk);
    exp_q.push_back(mk(1'b1, 1'b0, 32'h504, 32'h0, 32'h7777_7777, 4'hF, 1'b0));
    dm_addr = 32'h0000_0504; dm_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_req && n < 5);
    repeat (15) @(negedge clk);
    ready_en = 1'b1;
    @(negedge clk);
    dm_req = 1'b0;
    tests++;
    if (dm_valid !== 1'b1 || bus_err !== 1'b0 || dm_rdata !== 32'h7777_7777) begin
      fails++;
      $display("FAIL timeout_race: got valid=%b err=%b rdata=%h, required 1 0 77777777",
               dm_valid, bus_err, dm_rdata);
    end
`else
    exp_q.push_back(mk(1'b1, 1'b0, 32'h500, 32'h0, 32'h7777_7777, 4'hF, 1'b0));
    dm_req = 1'b1;
    @(negedge clk);
    repeat (120) begin
      @(negedge clk);
      if (!mem_req || dm_valid || bus_err) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL no_timeout: got %0d cycles without pending request, required 0", bad);
    end
    ready_en = 1'b1;
    do begin @(negedge clk); n++; end while (!dm_valid && n < 4);
    dm_req = 1'b0;
    tests++;
    if (dm_valid !== 1'b1 || bus_err !== 1'b0) begin
      fails++;
      $display("FAIL late_ready: got valid=%b err=%b, required 1 0", dm_valid, bus_err);
    end
`endif
    ready_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_fetch();
    test_byte_store();
    test_contention();
    test_reset_mid();
    test_timeout();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
